// File: rtl/param_memory.sv
// param_memory: single-port word memory with a power-up INIT sweep.
//
// After reset releases, the FSM spends DEPTH cycles in INIT, writing one
// word per cycle at ascending addresses. It then moves to IDLE and services
// one read or write per cycle.
// Build option: define MEM_PROG_IMAGE_EN to sweep a small boot program into
// the array instead of zeros. Sweep timing is the same in both builds.
//
// Handshake: an access is taken on a rising edge where req=1 and ready=1.
// Requests made while ready=0 are dropped, not queued. A read answers with a
// one-cycle rvalid pulse on the next cycle, with rdata held until the next
// read. An address >= DEPTH pulses err, never touches the array, and a read
// to such an address returns rdata=0.
module param_memory #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    init_cnt_q;
    logic                ready_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rvalid_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                in_range;
    logic                accept;
    logic [IDX_W-1:0]    addr_idx;
    logic [DATA_W-1:0]   init_word_d;

    // The whole address is compared, so high addresses never alias low words.
    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign accept   = req & ready_q;
    assign addr_idx = addr[IDX_W-1:0];

    // Word written by the INIT sweep at the current counter address.
    always_comb begin
        init_word_d = '0;
`ifdef MEM_PROG_IMAGE_EN
        case (32'(init_cnt_q))
            32'd0:  init_word_d = DATA_W'(20'h0A014);  // LOAD 20
            32'd1:  init_word_d = DATA_W'(20'h02015);  // ADD 21
            32'd2:  init_word_d = DATA_W'(20'h12016);  // STORE 22
            32'd3,
            32'd4,
            32'd5,
            32'd6:  init_word_d = DATA_W'(20'h38000);  // NOP
            32'd20: init_word_d = DATA_W'(20'h0002A);  // 42
            32'd21: init_word_d = DATA_W'(20'h00003);  // 3
            default: init_word_d = '0;
        endcase
`endif
    end

    // Array write port: sweep in INIT, in-range accepted writes in IDLE.
    // There is no reset on the array. Gating on rst keeps a held reset from
    // writing anything.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_INIT) begin
                mem[init_cnt_q] <= init_word_d;
            end else if (accept && we && in_range) begin
                mem[addr_idx] <= wdata;
            end
        end
    end

    // Control FSM with registered ready/rvalid/err/rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == LAST_IDX) begin
                        init_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                        ready_q    <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (!we) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= in_range ? mem[addr_idx] : '0;
                        end
                        if (!in_range) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign ready  = ready_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory (default parameters). The expected boot
// image follows MEM_PROG_IMAGE_EN, so compile bench and RTL with the same
// define.
module tb_param_memory;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              err;

    int tests_run    = 0;
    int tests_failed = 0;

    param_memory #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready),
        .rdata (rdata),
        .rvalid(rvalid),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Contents expected straight after an INIT sweep.
    function automatic logic [DATA_W-1:0] image_word(input int a);
        logic [DATA_W-1:0] w;
        w = '0;
`ifdef MEM_PROG_IMAGE_EN
        case (a)
            0:          w = 18'h0A014;
            1:          w = 18'h02015;
            2:          w = 18'h12016;
            3, 4, 5, 6: w = 18'h38000;
            20:         w = 18'h0002A;
            21:         w = 18'h00003;
            default:    w = '0;
        endcase
`endif
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b0; req = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({ready, rvalid, err, rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%0b rvalid=%0b err=%0b rdata=%h want all 0", ready, rvalid, err, rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (k < DEPTH) begin
                if ({ready, rvalid, err} !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL init_edge_%0d: ready/rvalid/err=%b want 000", k, {ready, rvalid, err});
                end
            end else if ({ready, rvalid, err} !== 3'b100) begin
                tests_failed++;
                $display("FAIL init_done_edge_%0d: ready/rvalid/err=%b want 100", k, {ready, rvalid, err});
            end
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({ready, rvalid, err} !== 3'b100) begin
            tests_failed++;
            $display("FAIL init_req_not_queued: ready/rvalid/err=%b want 100", {ready, rvalid, err});
        end
    endtask

    task automatic test_boot_image();
        int a[4] = '{0, 20, 21, 22};
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; we = 1'b0; addr = ADDR_W'(a[i]);
            @(posedge clk);
            #1;
            tests_run++;
            if ({rvalid, err, rdata} !== {2'b10, image_word(a[i])}) begin
                tests_failed++;
                $display("FAIL boot_read_%0d: rvalid=%0b err=%0b rdata=%h want 1 0 %h", a[i], rvalid, err, rdata, image_word(a[i]));
            end
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err, rdata} !== {2'b00, image_word(22)}) begin
            tests_failed++;
            $display("FAIL boot_rvalid_single: rvalid=%0b err=%0b rdata=%h want 0 0 %h", rvalid, err, rdata, image_word(22));
        end
    endtask

    task automatic test_write_read();
        req = 1'b1; we = 1'b1; addr = 13'd22; wdata = 18'h3FFFF;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err} !== 2'b00) begin
            tests_failed++;
            $display("FAIL write_22_no_rvalid: rvalid/err=%b want 00", {rvalid, err});
        end
        we = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err, rdata} !== {2'b10, 18'h3FFFF}) begin
            tests_failed++;
            $display("FAIL read_after_write_22: rvalid=%0b err=%0b rdata=%h want 1 0 3ffff", rvalid, err, rdata);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err, rdata} !== {2'b00, 18'h3FFFF}) begin
            tests_failed++;
            $display("FAIL rdata_hold: rvalid=%0b err=%0b rdata=%h want 0 0 3ffff", rvalid, err, rdata);
        end
    endtask

    task automatic test_back_to_back();
        int                a[5] = '{5, 30, 64, 100, 127};
        logic [DATA_W-1:0] d[5] = '{18'h00001, 18'h2AAAA, 18'h15555, 18'h3FFFE, 18'h0F0F0};
        for (int i = 0; i < 5; i++) begin
            req = 1'b1; we = 1'b1; addr = ADDR_W'(a[i]); wdata = d[i];
            @(posedge clk);
            #1;
            tests_run++;
            if ({rvalid, err} !== 2'b00) begin
                tests_failed++;
                $display("FAIL b2b_write_%0d: rvalid/err=%b want 00", a[i], {rvalid, err});
            end
            we = 1'b0;
            @(posedge clk);
            #1;
            tests_run++;
            if ({rvalid, err, rdata} !== {2'b10, d[i]}) begin
                tests_failed++;
                $display("FAIL b2b_read_%0d: rvalid=%0b err=%0b rdata=%h want 1 0 %h", a[i], rvalid, err, rdata, d[i]);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_out_of_range();
        req = 1'b1; we = 1'b1; addr = 13'd200; wdata = 18'h12345;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err} !== 2'b01) begin
            tests_failed++;
            $display("FAIL oor_write_200: rvalid/err=%b want 01", {rvalid, err});
        end
        we = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err, rdata} !== {2'b11, 18'h0}) begin
            tests_failed++;
            $display("FAIL oor_read_200: rvalid=%0b err=%0b rdata=%h want 1 1 0", rvalid, err, rdata);
        end
        addr = 13'd72;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err, rdata} !== {2'b10, image_word(72)}) begin
            tests_failed++;
            $display("FAIL alias_read_72: rvalid=%0b err=%0b rdata=%h want 1 0 %h", rvalid, err, rdata, image_word(72));
        end
        addr = 13'd127;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err, rdata} !== {2'b10, 18'h0F0F0}) begin
            tests_failed++;
            $display("FAIL edge_read_127: rvalid=%0b err=%0b rdata=%h want 1 0 0f0f0", rvalid, err, rdata);
        end
        addr = 13'd128;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err, rdata} !== {2'b11, 18'h0}) begin
            tests_failed++;
            $display("FAIL oor_read_128: rvalid=%0b err=%0b rdata=%h want 1 1 0", rvalid, err, rdata);
        end
        addr = 13'h1FFF;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err, rdata} !== {2'b11, 18'h0}) begin
            tests_failed++;
            $display("FAIL oor_read_8191: rvalid=%0b err=%0b rdata=%h want 1 1 0", rvalid, err, rdata);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err} !== 2'b00) begin
            tests_failed++;
            $display("FAIL oor_err_single: rvalid/err=%b want 00", {rvalid, err});
        end
    endtask

    task automatic test_reset_mid_init();
        req = 1'b1; we = 1'b0; addr = 13'd22;
        @(posedge clk);
        #1;
        req = 1'b0;
        tests_run++;
        if ({ready, rvalid, rdata} !== {2'b11, 18'h3FFFF}) begin
            tests_failed++;
            $display("FAIL pre_reset_read_22: ready=%0b rvalid=%0b rdata=%h want 1 1 3ffff", ready, rvalid, rdata);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({ready, rvalid, err, rdata} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset_idle: ready=%0b rvalid=%0b err=%0b rdata=%h want all 0", ready, rvalid, err, rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({ready, rvalid, err, rdata} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset_init60: ready=%0b rvalid=%0b err=%0b rdata=%h want all 0", ready, rvalid, err, rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (k < DEPTH) begin
                if ({ready, rvalid, err} !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL reinit_edge_%0d: ready/rvalid/err=%b want 000", k, {ready, rvalid, err});
                end
            end else if ({ready, rvalid, err} !== 3'b100) begin
                tests_failed++;
                $display("FAIL reinit_done_edge_%0d: ready/rvalid/err=%b want 100", k, {ready, rvalid, err});
            end
        end
        req = 1'b1; we = 1'b0; addr = 13'd22;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err, rdata} !== {2'b10, image_word(22)}) begin
            tests_failed++;
            $display("FAIL reinit_read_22: rvalid=%0b err=%0b rdata=%h want 1 0 %h", rvalid, err, rdata, image_word(22));
        end
        addr = 13'd5;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid, err, rdata} !== {2'b10, image_word(5)}) begin
            tests_failed++;
            $display("FAIL reinit_read_5: rvalid=%0b err=%0b rdata=%h want 1 0 %h", rvalid, err, rdata, image_word(5));
        end
        req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot_image();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 18, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 13, meaning address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 128, meaning implemented words; legal range 1 <= DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req, input, 1 bit: access request, sampled on each rising edge.
REQ-007 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read; meaningful only with req.
REQ-008 The block SHALL have port addr, input, ADDR_W bits: word address.
REQ-009 The block SHALL have port wdata, input, DATA_W bits: write data.
REQ-010 The block SHALL have port ready, output, 1 bit: 1 = block accepts requests this cycle.
REQ-011 The block SHALL have port rdata, output, DATA_W bits: read data.
REQ-012 The block SHALL have port rvalid, output, 1 bit: one-cycle pulse marking new rdata.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse marking an out-of-range access.

Function
REQ-014 The block SHALL implement a two-state FSM: INIT (array sweep, ready=0) and IDLE (service, ready=1).
REQ-015 In INIT, the block SHALL write one word per cycle at init counter addresses 0..DEPTH-1 in ascending order, then move to IDLE; ready SHALL rise at the DEPTH-th rising edge after rst deasserts.
REQ-016 An access SHALL be accepted only on an edge where req=1 and ready=1; requests with ready=0 SHALL be ignored and not queued.
REQ-017 An accepted read with addr < DEPTH SHALL load rdata with the stored word at that edge and assert rvalid for exactly the following cycle (latency 1).
REQ-018 rdata SHALL hold its last value until the next accepted read.
REQ-019 An accepted write with addr < DEPTH SHALL update the word at that edge, with no rvalid pulse.
REQ-020 A read in the cycle after a write to the same address SHALL return the new data.
REQ-021 Accesses SHALL be accepted back-to-back every cycle in IDLE, with one rvalid per read.
REQ-022 An accepted access with addr >= DEPTH SHALL assert err for one cycle and SHALL NOT modify the array.
REQ-023 For an out-of-range read, the block SHALL also pulse rvalid with rdata = 0.
REQ-024 The full ADDR_W-bit address SHALL be compared against DEPTH, with no wrap or aliasing.

Reset
REQ-025 While rst=0, the block SHALL force ready=0, rvalid=0, err=0, rdata=0, init counter=0 and state=INIT, asynchronously.
REQ-026 Array contents SHALL NOT be reset asynchronously; they SHALL be set only by the INIT sweep.
REQ-027 Reset asserted mid-INIT or mid-access SHALL abort it; the sweep SHALL restart from address 0 after release.

Configuration
REQ-028 Macro MEM_PROG_IMAGE_EN SHALL control the INIT sweep contents.
REQ-029 With MEM_PROG_IMAGE_EN defined, the INIT sweep SHALL write the boot image (hex, zero-extended or truncated to DATA_W):
  - word 0 = 0x0A014 (LOAD 20)
  - word 1 = 0x02015 (ADD 21)
  - word 2 = 0x12016 (STORE 22)
  - words 3..6 = 0x38000 (NOP)
  - word 20 = 0x0002A (42)
  - word 21 = 0x00003 (3)
  - all other words = 0
  - image words at addresses >= DEPTH are skipped
REQ-030 Without MEM_PROG_IMAGE_EN, the INIT sweep SHALL write 0 to every word; sweep timing SHALL be identical in both builds.

Verification
REQ-031 The bench SHALL cover: release rst, hold req=1 throughout -> ready=0 for edges 1..127, ready=1 after edge 128, no rvalid/err before then.
REQ-032 The bench SHALL cover (MEM_PROG_IMAGE_EN defined): reads of addr 0, 20, 21, 22 -> rdata 0x0A014, 0x0002A, 0x00003, 0x00000, each rvalid one cycle after request; without the macro -> all 0.
REQ-033 The bench SHALL cover: write 0x3FFFF to addr 22, read addr 22 next cycle -> rvalid=1, rdata=0x3FFFF; alternating back-to-back write/read of 5 addresses -> correct data each cycle.
REQ-034 The bench SHALL cover: write addr 200 with 0x12345, then read addr 200 -> err pulses on both, read gives rvalid=1 and rdata=0; a later read of addr 200-128=72 is unaffected.
REQ-035 The bench SHALL cover: rst pulsed low at edge 60 of INIT -> outputs zero immediately, ready rises 128 edges after re-release, and a previously written address returns its image/zero value.
